// File: rtl/index_fifo.sv
// -----------------------------------------------------------------------------
// index_fifo
//   Small synchronous FIFO that buffers encoder indices between an upstream
//   producer and a downstream consumer using a valid/ready handshake.
//
// Ports
//   clk        : single clock, all state updates on its rising edge
//   rst        : asynchronous, active-high reset (clears pointers, count, overflow)
//   flush      : synchronous clear of all entries (overflow is kept)
//   in_valid   : upstream index valid this cycle
//   in_index   : index to enqueue (IW bits)
//   in_ready   : FIFO can accept a write this cycle (count < DEPTH)
//   out_valid  : out_index holds the oldest stored entry (count != 0)
//   out_index  : oldest stored index
//   out_ready  : downstream takes out_index this cycle
//   count      : number of stored entries
//   overflow   : sticky flag, set when a write is attempted while full
// -----------------------------------------------------------------------------
module index_fifo #(
    parameter int encoderWidth = 16,
    parameter int DEPTH        = 4,
    localparam int IW          = $clog2(encoderWidth),
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [IW-1:0] in_index,
    output logic          in_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_index,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic          overflow
);

    logic [IW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          wr_en, rd_en;

    // Handshake flags depend only on registered count, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (cnt_q < CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign out_index = mem_q[rd_ptr_q];
    assign count     = cnt_q;
    assign overflow  = ovf_q;

    always_comb begin
        wr_en    = in_valid && in_ready && !flush;
        rd_en    = out_valid && out_ready && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (flush) begin
            // Flush overrides any write/read this cycle and never touches overflow.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // Pointers are exactly PW bits wide; DEPTH is a power of two so
            // the natural rollover wraps DEPTH-1 -> 0.
            if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
            if (in_valid && !in_ready) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; stale contents are never visible because
    // out_valid gates them.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_index;
    end

endmodule

// File: tb/tb_index_fifo.sv
module tb_index_fifo;

    localparam int EW    = 16;
    localparam int DEPTH = 4;
    localparam int IW    = $clog2(EW);
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] in_index;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_index;
    logic          out_ready;
    logic [CW-1:0] count;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of stored values plus the sticky flag.
    logic [IW-1:0] q[$];
    bit            ovf_m;

    always #5 clk = ~clk;

    index_fifo #(.encoderWidth(EW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_index (in_index),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_index(out_index),
        .out_ready(out_ready),
        .count    (count),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":count"},     32'(count),     32'(q.size()));
        chk({where, ":out_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({where, ":in_ready"},  32'(in_ready),  32'(q.size() < DEPTH));
        chk({where, ":overflow"},  32'(overflow),  32'(ovf_m));
        if (q.size() != 0) chk({where, ":out_index"}, 32'(out_index), 32'(q[0]));
    endtask

    // One clock cycle: drive inputs, advance the model on the edge, check after.
    task automatic cyc(input bit iv, input logic [IW-1:0] idx, input bit ordy, input bit fl,
                       input string where);
        bit wr, rd;
        in_valid  = iv;
        in_index  = idx;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            wr = iv && (q.size() < DEPTH);
            rd = ordy && (q.size() > 0);
            if (iv && q.size() == DEPTH) ovf_m = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(idx);
        end
        #1;
        check_all(where);
    endtask

    // Asynchronous reset pulse between edges, checked before any clock edge.
    task automatic areset(input string where);
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        ovf_m = 1'b0;
        check_all(where);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_index = '0; out_ready = 1'b0;
        ovf_m = 1'b0;
        #12;
        check_all("reset");
        rst = 1'b0;

        // Three writes, then drain in order.
        cyc(1, 4'd3,  0, 0, "w3");
        cyc(1, 4'd7,  0, 0, "w7");
        cyc(1, 4'd15, 0, 0, "w15");
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, "drain3");

        // Flush while full with a write pending must not set overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1, IW'(i + 1), 0, 0, "fill_a");
        cyc(1, 4'd9, 0, 1, "flush_full");

        // count=3, flush together with write and read.
        for (int i = 0; i < 3; i++) cyc(1, IW'(i + 10), 0, 0, "fill_b");
        cyc(1, 4'd6, 1, 1, "flush_wr_rd");
        cyc(0, '0, 0, 0, "after_flush");

        // Fill, attempt write while full, drain; extra read when empty.
        cyc(1, 4'd1, 0, 0, "f1");
        cyc(1, 4'd2, 0, 0, "f2");
        cyc(1, 4'd4, 0, 0, "f4");
        cyc(1, 4'd8, 0, 0, "f8");
        cyc(1, 4'd9, 0, 0, "ovf_write");
        for (int i = 0; i < 5; i++) cyc(0, '0, 1, 0, "drain_ovf");

        // Simultaneous read/write at count=2 over enough cycles to wrap.
        cyc(1, 4'd5, 0, 0, "pre1");
        cyc(1, 4'd12, 0, 0, "pre2");
        for (int i = 0; i < 10; i++) cyc(1, IW'(i + 5), 1, 0, "rdwr");
        cyc(1, 4'd3, 1, 1, "flush_ovf_kept");

        // Async reset mid-operation with count=2 and overflow set.
        cyc(1, 4'd2, 0, 0, "pr1");
        cyc(1, 4'd3, 0, 0, "pr2");
        areset("async_rst");

        // Full index width: 15 then 0 back-to-back, written right after reset.
        cyc(1, 4'd15, 0, 0, "w_max");
        cyc(1, 4'd0,  0, 0, "w_zero");
        cyc(0, '0, 1, 0, "r_max");
        cyc(0, '0, 1, 0, "r_zero");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), IW'($urandom_range(0, EW - 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), "rand");
            if (i % 97 == 96) areset("rand_rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/index_fifo.md
INDEX_FIFO -- requirements
Module: index_fifo

Interface
REQ-001 Parameter encoderWidth, default 16, SHALL set the index range to 0..encoderWidth-1; index width IW = $clog2(encoderWidth).
REQ-002 Parameter DEPTH, default 4, SHALL set the number of entries and SHALL be a power of two, at least 2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 flush  input  1  SHALL be a synchronous clear of all entries.
REQ-006 in_valid  input  1  SHALL indicate the upstream encoder index is valid this cycle.
REQ-007 in_index  input  IW  SHALL be the index to enqueue.
REQ-008 in_ready  output  1  SHALL indicate the FIFO accepts a write this cycle.
REQ-009 out_valid  output  1  SHALL indicate out_index holds the oldest stored entry.
REQ-010 out_index  output  IW  SHALL be the oldest stored index.
REQ-011 out_ready  input  1  SHALL indicate the downstream consumer takes out_index this cycle.
REQ-012 count  output  $clog2(DEPTH)+1  SHALL be the number of stored entries.
REQ-013 overflow  output  1  SHALL be a sticky flag marking a dropped write.

Function
REQ-014 A write SHALL occur on a rising edge where in_valid=1 and in_ready=1; a read SHALL occur where out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL equal (count < DEPTH), with no combinational path from out_ready.
REQ-016 out_valid SHALL equal (count != 0), and out_index SHALL equal the entry at the read pointer.
REQ-017 Latency: an entry written at edge N SHALL appear on out_valid and out_index after edge N, with no same-cycle bypass when empty.
REQ-018 Write and read pointers SHALL each be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-019 Count update: +1 on write only, -1 on read only, unchanged on a simultaneous write and read (legal only when 0 < count < DEPTH).
REQ-020 When full, in_valid=1 SHALL NOT write, and SHALL set overflow to 1 on that edge.
REQ-021 overflow SHALL remain 1 until rst is asserted; flush SHALL NOT clear it.
REQ-022 flush=1 SHALL set count=0 and both pointers to 0 on the edge, and SHALL override any write or read in the same cycle; storage contents need not be cleared.
REQ-023 When flush=1 and in_valid=1 with the FIFO full, overflow SHALL NOT be set.
REQ-024 When empty, out_ready=1 SHALL have no effect.
REQ-025 Entries SHALL leave in write order, with values unmodified.

Reset
REQ-026 Asserting rst SHALL immediately and asynchronously set count=0, both pointers=0, overflow=0, out_valid=0 and in_ready=1.
REQ-027 Reset SHALL be honoured mid-operation, including partial fill and simultaneous read/write; stored entries are discarded.
REQ-028 After rst is released, the first write SHALL be possible on the next rising edge.
REQ-029 Storage array contents SHALL NOT require reset.

Verification
REQ-030 Reset then write 3, 7, 15 on consecutive edges with out_ready=0 -> count=3; then out_ready=1 -> out_index 3, 7, 15 in order, out_valid=0 after the third read.
REQ-031 Write 4 entries (DEPTH=4) then in_valid=1 index 9 -> in_ready=0, count=4, overflow=1; reading returns the original 4 only.
REQ-032 With count=2, simultaneous write 5 and read -> count stays 2; run 10 such cycles -> pointers wrap and order is preserved.
REQ-033 With count=3, assert flush together with a write and a read -> count=0 and out_valid=0 on the next cycle; overflow is unchanged.
REQ-034 With count=2 and overflow=1, assert rst between edges -> count=0, overflow=0, in_ready=1 without waiting for a clock edge.
REQ-035 Write index encoderWidth-1 (15) and index 0 back-to-back -> read back as 15 then 0, confirming the full IW width is carried.
